// File: rtl/digit_scan_controller_pkg.sv
// Shared encodings for the two-digit scan display path: count states, mode codes,
// active-low segment patterns and the value-to-digits split.
package digit_scan_controller_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10
    } count_state_e;

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_UP       = 2'b01;
    localparam logic [1:0] MODE_DOWN     = 2'b10;
    localparam logic [1:0] MODE_HOLD_ALT = 2'b11;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } digit_pair_t;

    // 0..15 shown as two decimal digits; tens is only ever 0 or 1.
    function automatic digit_pair_t split_digits(input logic [3:0] v);
        digit_pair_t d;
        if (v >= 4'd10) begin
            d.tens = 4'd1;
            d.ones = v - 4'd10;
        end else begin
            d.tens = 4'd0;
            d.ones = v;
        end
        return d;
    endfunction

    function automatic count_state_e mode_to_state(input logic [1:0] m);
        count_state_e s;
        case (m)
            MODE_UP:       s = ST_UP;
            MODE_DOWN:     s = ST_DOWN;
            MODE_HOLD,
            MODE_HOLD_ALT: s = ST_HOLD;
            default:       s = ST_HOLD;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/digit_scan_controller_seg7.sv
// Combinational decimal digit to active-low 7-segment pattern; codes 10..15 blank.
module seg7_digit_decode
    import digit_scan_controller_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (digit)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/digit_scan_controller.sv
// 4-bit up/down counter with prescaled stepping, shown as two multiplexed
// decimal digits on one shared active-low 7-segment bus.
module digit_scan_controller
    import digit_scan_controller_pkg::*;
#(
    parameter int unsigned PRESCALE = 25000000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [1:0] mode,
    output logic [3:0] value,
    output logic [6:0] seg,
    output logic [1:0] dig_en,
    output logic       wrap
);

    localparam int unsigned PRE_W  = $clog2(PRESCALE);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    count_state_e      state_q, state_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [3:0]        value_q, value_d;
    logic              wrap_q, wrap_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic              scan_sel_q, scan_sel_d;
    logic [6:0]        seg_q, seg_d;
    logic [1:0]        dig_en_q, dig_en_d;

    digit_pair_t       digits_c;
    logic [3:0]        shown_digit_c;
    logic [6:0]        shown_seg_c;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_HOLD;
            presc_q    <= '0;
            value_q    <= 4'd0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            scan_sel_q <= 1'b0;
            seg_q      <= SEG_0;
            dig_en_q   <= 2'b10;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            value_q    <= value_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            scan_sel_q <= scan_sel_d;
            seg_q      <= seg_d;
            dig_en_q   <= dig_en_d;
        end
    end

    // Count FSM: a state change or HOLD restarts the prescaler; load beats a step.
    always_comb begin
        state_d = mode_to_state(mode);
        presc_d = presc_q;
        value_d = value_q;
        wrap_d  = 1'b0;
        if (load) begin
            value_d = load_val;
            presc_d = '0;
        end else if ((state_d != state_q) || (state_q == ST_HOLD)) begin
            presc_d = '0;
        end else if (presc_q == PRE_LAST) begin
            presc_d = '0;
            if (state_q == ST_UP) begin
                value_d = value_q + 4'd1;
                wrap_d  = (value_q == 4'hF);
            end else begin
                value_d = value_q - 4'd1;
                wrap_d  = (value_q == 4'h0);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
        end
    end

    // Free-running digit slot timer.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_sel_d = scan_sel_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_sel_d = ~scan_sel_q;
        end
    end

    assign digits_c      = split_digits(value_q);
    assign shown_digit_c = scan_sel_q ? digits_c.tens : digits_c.ones;

    seg7_digit_decode u_seg7_digit_decode (
        .digit (shown_digit_c),
        .seg_c (shown_seg_c)
    );

    // Exactly one digit enabled at a time, always paired with its pattern.
    always_comb begin
        seg_d    = shown_seg_c;
        dig_en_d = scan_sel_q ? 2'b01 : 2'b10;
    end

    assign value  = value_q;
    assign wrap   = wrap_q;
    assign seg    = seg_q;
    assign dig_en = dig_en_q;

endmodule

// File: tb/tb_digit_scan_controller.sv
// Scoreboard bench for digit_scan_controller: a driver advances a cycle-level
// reference model and queues expected outputs; a monitor pops and compares.
module tb_digit_scan_controller;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned SCAN_DIV = 3;

    logic       clk      = 1'b0;
    logic       resetn   = 1'b1;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [1:0] mode     = 2'b00;
    logic [3:0] value;
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic       wrap;

    digit_scan_controller #(
        .PRESCALE (PRESCALE),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .value    (value),
        .seg      (seg),
        .dig_en   (dig_en),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned tag;
        logic [3:0]  value;
        logic [6:0]  seg;
        logic [1:0]  dig_en;
        logic        wrap;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    // Reference model: value, cycles elapsed in the current run, effective mode
    // (0 hold, 1 up, 2 down) and edges since reset for the slot schedule.
    int m_value   = 0;
    int m_elapsed = 0;
    int m_eff     = 0;
    int m_n       = 0;

    always @(posedge clk) edge_cnt++;

    function automatic exp_t reset_exp(input int unsigned tag);
        exp_t e;
        e.tag    = tag;
        e.value  = 4'd0;
        e.seg    = 7'b1000000;
        e.dig_en = 2'b10;
        e.wrap   = 1'b0;
        return e;
    endfunction

    task automatic model_edge(input bit ld, input int lv, input int md, output exp_t e);
        int eff;
        bit tens_slot;
        tens_slot = ((m_n / SCAN_DIV) % 2) == 1;
        e.seg    = tens_slot ? seg_tab[m_value / 10] : seg_tab[m_value % 10];
        e.dig_en = tens_slot ? 2'b01 : 2'b10;
        e.wrap   = 1'b0;
        eff = (md == 1) ? 1 : (md == 2) ? 2 : 0;
        if (ld) begin
            m_value   = lv;
            m_elapsed = 0;
        end else if (eff != m_eff || m_eff == 0) begin
            m_elapsed = 0;
        end else begin
            m_elapsed++;
            if (m_elapsed == PRESCALE) begin
                m_elapsed = 0;
                if (eff == 1) begin
                    e.wrap  = (m_value == 15);
                    m_value = (m_value + 1) % 16;
                end else begin
                    e.wrap  = (m_value == 0);
                    m_value = (m_value + 15) % 16;
                end
            end
        end
        m_eff   = eff;
        m_n++;
        e.value = 4'(m_value);
        e.tag   = edge_cnt + 1;
    endtask

    // One clock of normal operation; called at posedge+1.
    task automatic step(input bit ld, input logic [3:0] lv, input logic [1:0] md);
        exp_t e;
        resetn   = 1'b1;
        load     = ld;
        load_val = lv;
        mode     = md;
        model_edge(ld, int'(lv), int'(md), e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset(input int ncyc);
        @(negedge clk);
        #2;
        load      = 1'b0;
        resetn    = 1'b0;
        m_value   = 0;
        m_elapsed = 0;
        m_eff     = 0;
        m_n       = 0;
        exp_q.push_back(reset_exp(edge_cnt));
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            exp_q.push_back(reset_exp(edge_cnt));
        end
        @(posedge clk);
        #1;
        exp_q.push_back(reset_exp(edge_cnt));
    endtask

    task automatic chk(input string name, input int got, input int want, input int unsigned tag);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, tag, got, want);
        end
    endtask

    // Monitor: compare every expectation whose edge has already occurred.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge resetn);
            #1;
            while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) begin
                e = exp_q.pop_front();
                chk("value",  int'(value),  int'(e.value),  e.tag);
                chk("seg",    int'(seg),    int'(e.seg),    e.tag);
                chk("dig_en", int'(dig_en), int'(e.dig_en), e.tag);
                chk("wrap",   int'(wrap),   int'(e.wrap),   e.tag);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset(2);

        // Count up to 7, then reset mid-count and restart counting up.
        for (int i = 0; i < 100 && m_value != 7; i++) step(1'b0, 4'd0, 2'b01);
        mode = 2'b01;
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 2'b01);

        // Up wrap 15 -> 0.
        step(1'b1, 4'd14, 2'b01);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 2'b01);

        // Down wrap 0 -> 15, then frozen in mode 11.
        step(1'b1, 4'd1, 2'b10);
        for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 2'b10);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 2'b11);

        // Load coinciding with the final prescaler cycle.
        for (int i = 0; i < 20 && !(m_eff == 1 && m_elapsed == int'(PRESCALE) - 1); i++)
            step(1'b0, 4'd0, 2'b01);
        step(1'b1, 4'd5, 2'b01);
        for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 2'b01);

        // Scan of value 12 while holding.
        step(1'b1, 4'd12, 2'b00);
        for (int i = 0; i < 14; i++) step(1'b0, 4'd0, 2'b00);

        // UP -> DOWN switch mid-prescale.
        for (int i = 0; i < 20 && !(m_eff == 1 && m_elapsed == 2); i++)
            step(1'b0, 4'd0, 2'b01);
        for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 2'b10);

        // Randomized operation.
        begin
            logic [1:0] md;
            md = 2'b01;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 149) == 0) begin
                    do_reset(int'($urandom_range(1, 3)));
                end else begin
                    if ($urandom_range(0, 9) == 0) md = 2'($urandom_range(0, 3));
                    step($urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), md);
                end
            end
        end

        repeat (3) @(negedge clk);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0, edge_cnt);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
